inst_fetch_mem: RTL and testbench

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

---
 rtl/inst_fetch_mem.sv | 153 +++++++++++++++
 tb/tb_inst_fetch_mem.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: a word-organised program store with a fixed-latency
// fetch port (ready/valid handshake) and a single-cycle program-load port.
module inst_fetch_mem #(
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           DEPTH       = 64,
  parameter int unsigned           WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD   = 16'hEFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  exc,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_err
);

  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_WIDTH-2:0] WORD_LIM = (ADDR_WIDTH - 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic                  pend_exc_q, pend_exc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  exc_q, exc_d;
  logic                  load_err_q, load_err_d;

  // Words are held XOR HALT_WORD, so an all-zero power-up image reads back as
  // HALT_WORD everywhere without any initialisation pass.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept;
  logic                  fetch_ok;
  logic                  load_ok;
  logic                  mem_we;
  logic [IDX_W-1:0]      fetch_idx;
  logic [IDX_W-1:0]      load_idx;
  logic [DATA_WIDTH-1:0] fetch_word;

  function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
    return !a[0] && (a[ADDR_WIDTH-1:1] < WORD_LIM);
  endfunction

  assign ready  = (state_q != ST_WAIT);
  assign valid  = (state_q == ST_RESP);
  assign accept = req && ready;

  assign fetch_ok   = addr_legal(addr);
  assign fetch_idx  = addr[IDX_W:1];
  assign fetch_word = fetch_ok ? (mem_q[fetch_idx] ^ HALT_WORD) : '0;

  assign load_ok  = addr_legal(load_addr);
  assign load_idx = load_addr[IDX_W:1];
  assign mem_we   = load_en && load_ok;

  // NOTE: every variable gets its hold value first, so no path through this
  // block can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_data_d = pend_data_q;
    pend_exc_d  = pend_exc_q;
    data_d      = data_q;
    exc_d       = exc_q;
    load_err_d  = load_en && !load_ok;

    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
            data_d  = fetch_word;
            exc_d   = !fetch_ok;
          end else begin
            state_d     = ST_WAIT;
            cnt_d       = CNT_INIT;
            pend_data_d = fetch_word;
            pend_exc_d  = !fetch_ok;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_RESP;
          data_d  = pend_data_q;
          exc_d   = pend_exc_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: non-blocking updates make every flop and the memory sample pre-edge
  // values, which is what lets a same-edge load and fetch return the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_data_q <= '0;
      pend_exc_q  <= 1'b0;
      data_q      <= '0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_data_q <= pend_data_d;
      pend_exc_q  <= pend_exc_d;
      data_q      <= data_d;
      exc_q       <= exc_d;
    end
  end

  // NOTE: the storage array is deliberately not cleared by reset; reset only
  // blocks writes, so a loaded program survives a reset pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
      if (mem_we) begin
        mem_q[load_idx] <= load_data ^ HALT_WORD;
      end
    end
  end

  assign data     = data_q;
  assign exc      = exc_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Self-checking bench for inst_fetch_mem: a WAIT_STATES=2 instance driven from a
// vector table plus corner sequences, and a WAIT_STATES=0 instance for streaming.
module tb_inst_fetch_mem;

  localparam int WS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, ready, valid, exc, load_en, load_err;
  logic [15:0] addr, data, load_addr, load_data;
  logic        req0, ready0, valid0, exc0, load_en0, load_err0;
  logic [15:0] addr0, data0, load_addr0, load_data0;

  inst_fetch_mem #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(64), .WAIT_STATES(WS), .HALT_WORD(16'hEFFF)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .ready(ready), .valid(valid),
    .data(data), .exc(exc), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_err(load_err)
  );

  inst_fetch_mem #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(64), .WAIT_STATES(0), .HALT_WORD(16'hEFFF)
  ) dut0 (
    .clk(clk), .rst(rst), .req(req0), .addr(addr0), .ready(ready0), .valid(valid0),
    .data(data0), .exc(exc0), .load_en(load_en0), .load_addr(load_addr0),
    .load_data(load_data0), .load_err(load_err0)
  );

  typedef struct {
    logic [15:0] data;
    logic        exc;
  } resp_t;

  typedef struct {
    logic        do_load;
    logic [15:0] la;
    logic [15:0] ld;
    logic        lerr;
    logic [15:0] fa;
    logic [15:0] ed;
    logic        ee;
  } vec_t;

  resp_t       exp_q[$];
  resp_t       mon_e;
  vec_t        vecs[11];
  logic [15:0] model_mem[64];
  logic [15:0] last_data;
  int          n_vec   = 0;
  int          n_err   = 0;
  int          n_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic e);
    resp_t r;
    r.data = d;
    r.exc  = e;
    exp_q.push_back(r);
  endtask

  // Scoreboard: every valid pulse of the main instance must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'b0, valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_data", {16'b0, data}, {16'b0, mon_e.data});
        check("resp_exc", {31'b0, exc}, {31'b0, mon_e.exc});
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_queue", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] ed, input logic ee);
    int lat;
    @(negedge clk);
    check("ready_idle", {31'b0, ready}, 32'd1);
    req  = 1'b1;
    addr = a;
    push_exp(ed, ee);
    @(negedge clk);
    req  = 1'b0;
    addr = ~a;
    lat  = 1;
    while (valid !== 1'b1 && lat < 10) begin
      check("ready_wait", {31'b0, ready}, 32'd0);
      check("data_hold", {16'b0, data}, {16'b0, last_data});
      @(negedge clk);
      lat++;
    end
    check("latency", lat, WS + 1);
    if (valid !== 1'b1) exp_q.delete();
    last_data = ed;
  endtask

  task automatic load(input logic [15:0] la, input logic [15:0] ld, input logic exp_err);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = la;
    load_data = ld;
    @(negedge clk);
    load_en = 1'b0;
    check("load_err", {31'b0, load_err}, {31'b0, exp_err});
    if (!la[0] && la[15:1] < 15'd64) model_mem[la[6:1]] = ld;
    @(negedge clk);
    check("load_err_pulse", {31'b0, load_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    logic [15:0] exp0[3];
    int          accepts;
    int          nv;

    rst = 1'b0; req = 1'b0; addr = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    req0 = 1'b0; addr0 = '0; load_en0 = 1'b0; load_addr0 = '0; load_data0 = '0;
    for (int i = 0; i < 64; i++) model_mem[i] = 16'hEFFF;
    last_data = '0;

    //          load   l_addr    l_data    l_err  f_addr    exp_data  exp_exc
    vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'hEFFF, 1'b0};
    vecs[1]  = '{1'b1, 16'h0004, 16'h012F, 1'b0, 16'h0004, 16'h012F, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0005, 16'h0000, 1'b1};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0080, 16'h0000, 1'b1};
    vecs[4]  = '{1'b1, 16'h007E, 16'h5A5A, 1'b0, 16'h007E, 16'h5A5A, 1'b0};
    vecs[5]  = '{1'b1, 16'h0081, 16'h1111, 1'b1, 16'h0000, 16'hEFFF, 1'b0};
    vecs[6]  = '{1'b1, 16'h0003, 16'h2222, 1'b1, 16'h0002, 16'hEFFF, 1'b0};
    vecs[7]  = '{1'b1, 16'h0006, 16'hBEEF, 1'b0, 16'h0004, 16'h012F, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0006, 16'hBEEF, 1'b0};
    vecs[9]  = '{1'b1, 16'hFFFE, 16'h3333, 1'b1, 16'h007E, 16'h5A5A, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h007F, 16'h0000, 1'b1};

    // Reset state
    #1;
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_data", {16'b0, data}, 32'd0);
    check("rst_exc", {31'b0, exc}, 32'd0);
    check("rst_load_err", {31'b0, load_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].do_load) load(vecs[i].la, vecs[i].ld, vecs[i].lerr);
      fetch(vecs[i].fa, vecs[i].ed, vecs[i].ee);
    end

    // Same-edge load and fetch: fetch sees the old word, the write still lands.
    load(16'h0010, 16'h1234, 1'b0);
    @(negedge clk);
    req = 1'b1; addr = 16'h0010;
    load_en = 1'b1; load_addr = 16'h0010; load_data = 16'hABCD;
    push_exp(16'h1234, 1'b0);
    @(negedge clk);
    req = 1'b0; load_en = 1'b0;
    model_mem[8] = 16'hABCD;
    drain(8);
    last_data = 16'h1234;
    fetch(16'h0010, 16'hABCD, 1'b0);

    // Load during WAIT leaves the pending response alone; req in WAIT is ignored.
    @(negedge clk);
    req = 1'b1; addr = 16'h0020;
    push_exp(16'hEFFF, 1'b0);
    @(negedge clk);
    addr = 16'h0004;
    load_en = 1'b1; load_addr = 16'h0020; load_data = 16'h7777;
    @(negedge clk);
    req = 1'b0; load_en = 1'b0;
    check("load_err_in_wait", {31'b0, load_err}, 32'd0);
    model_mem[16] = 16'h7777;
    drain(8);
    repeat (4) @(negedge clk);
    last_data = 16'hEFFF;
    fetch(16'h0020, 16'h7777, 1'b0);

    // req held high with WAIT_STATES=2: accepts only land in IDLE/RESP.
    accepts = 0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      a = (i % 2 == 1) ? 16'h0006 : 16'h0004;
      req = 1'b1; addr = a;
      if (ready === 1'b1) begin
        push_exp(model_mem[a[6:1]], 1'b0);
        accepts++;
        last_data = model_mem[a[6:1]];
      end
      @(negedge clk);
    end
    req = 1'b0;
    check("held_req_accepts", accepts, 32'd3);
    drain(12);

    // WAIT_STATES=0 instance: one response per cycle with req held high.
    exp0[0] = 16'h1000; exp0[1] = 16'h2002; exp0[2] = 16'h3004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load_en0 = 1'b1; load_addr0 = 16'(2 * i); load_data0 = exp0[i];
    end
    @(negedge clk);
    load_en0 = 1'b0;
    check("ws0_load_err", {31'b0, load_err0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      req0 = 1'b1; addr0 = 16'(2 * i);
      @(negedge clk);
      check("ws0_valid", {31'b0, valid0}, 32'd1);
      check("ws0_ready", {31'b0, ready0}, 32'd1);
      check("ws0_data", {16'b0, data0}, {16'b0, exp0[i]});
      check("ws0_exc", {31'b0, exc0}, 32'd0);
    end
    req0 = 1'b0;
    @(negedge clk);
    check("ws0_valid_drop", {31'b0, valid0}, 32'd0);
    check("ws0_data_hold", {16'b0, data0}, 32'h3004);

    // Reset in WAIT: outputs clear at once, the pending response is dropped,
    // loads are ignored during reset and memory survives.
    @(negedge clk);
    req = 1'b1; addr = 16'h0006;
    push_exp(16'hBEEF, 1'b0);
    @(negedge clk);
    req = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, valid}, 32'd0);
    check("async_rst_ready", {31'b0, ready}, 32'd1);
    check("async_rst_data", {16'b0, data}, 32'd0);
    check("async_rst_exc", {31'b0, exc}, 32'd0);
    exp_q.delete();
    load_en = 1'b1; load_addr = 16'h0004; load_data = 16'hDEAD;
    repeat (2) @(negedge clk);
    check("rst_load_err_hold", {31'b0, load_err}, 32'd0);
    load_en = 1'b0;
    rst = 1'b1;
    nv = n_valid;
    repeat (6) @(negedge clk);
    #1;
    check("no_valid_after_rst", n_valid, nv);
    last_data = '0;
    fetch(16'h0004, model_mem[2], 1'b0);
    fetch(16'h007E, model_mem[63], 1'b0);
    fetch(16'h0010, model_mem[8], 1'b0);
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
